// File: rtl/adder_share_pkg.sv
// Shared definitions for the adder_share_arbiter block.
//   adder_share_state_t : response-register state (IDLE = empty, HOLD = valid)
//   ADDER_SHARE_WIDTH   : width of the shared carry-select adder
package adder_share_pkg;

    localparam int ADDER_SHARE_WIDTH = 32;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } adder_share_state_t;

endpackage

// File: rtl/adder_share_arbiter_csel_add.sv
// csel_add32: 32-bit carry-select adder built from 4-bit blocks.
// Each block precomputes sums for carry-in 0 and 1; the incoming block
// carry selects between them.
// Ports:
//   a, b [32] : operands
//   cin       : carry-in
//   s    [32] : sum (modulo 2^32)
//   cout      : carry-out (bit 32 of a+b+cin)
module csel_add32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] s,
    output logic        cout
);

    logic [8:0] c;

    assign c[0] = cin;

    for (genvar g = 0; g < 8; g++) begin : g_blk
        logic [4:0] r0;
        logic [4:0] r1;
        assign r0             = {1'b0, a[4*g +: 4]} + {1'b0, b[4*g +: 4]};
        assign r1             = r0 + 5'd1;
        assign s[4*g +: 4]    = c[g] ? r1[3:0] : r0[3:0];
        assign c[g+1]         = c[g] ? r1[4]   : r0[4];
    end

    assign cout = c[8];

endmodule

// File: rtl/adder_share_arbiter_rr_pick.sv
// rr_pick: combinational round-robin winner select.
// Ports:
//   valid [NUM_REQ]  : request vector
//   ptr   [ID_W]     : highest-priority index (must be < NUM_REQ)
//   grant [NUM_REQ]  : one-hot winner, zero when nothing is valid
//   idx   [ID_W]     : encoded winner index (0 when nothing is valid)
//   any              : at least one request valid
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx,
    output logic               any
);

    logic [ID_W-1:0] cand;

    // Scan ptr, ptr+1, ... modulo NUM_REQ; first valid entry wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = ID_W'((32'(ptr) + k) % 32'(NUM_REQ));
            if (!any && valid[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: round-robin sharing of one 32-bit carry-select adder
// among NUM_REQ requesters, with a registered, ID-tagged response stage.
// Optional feature macro: ADDER_SHARE_OVF_EN (adds registered rsp_ovf).
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   req_valid/req_ready  : per-requester handshake (req_ready one-hot or zero)
//   req_a, req_b         : packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_cin              : per-requester carry-in
//   rsp_valid/rsp_ready  : response handshake
//   rsp_id, rsp_s        : winner index and sum
//   rsp_cout             : carry-out
//   rsp_ovf              : signed overflow (ADDER_SHARE_OVF_EN only)
module adder_share_arbiter
    import adder_share_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ-1:0]       req_cin,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH-1:0]         rsp_s,
    output logic                     rsp_cout
`ifdef ADDER_SHARE_OVF_EN
    ,
    output logic                     rsp_ovf
`endif
);

    if (WIDTH != ADDER_SHARE_WIDTH) begin : g_width_check
        $error("adder_share_arbiter: WIDTH must equal 32");
    end
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_num_req_check
        $error("adder_share_arbiter: NUM_REQ must be in 2..8");
    end

    adder_share_state_t state;
    logic [ID_W-1:0]    ptr;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    idx;
    logic               any;
    logic               can_issue;
    logic               accept;
    logic [WIDTH-1:0]   a_sel;
    logic [WIDTH-1:0]   b_sel;
    logic               cin_sel;
    logic [WIDTH-1:0]   sum;
    logic               cout;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .valid (req_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (idx),
        .any   (any)
    );

    assign can_issue = (state == IDLE) | rsp_ready;
    // Ready is a function of the winner only, never of its own valid bit
    // beyond selection; forced low throughout reset.
    assign req_ready = (rst || !can_issue) ? '0 : grant;
    assign accept    = any & can_issue & ~rst;

    always_comb begin
        a_sel   = '0;
        b_sel   = '0;
        cin_sel = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (idx == ID_W'(k)) begin
                a_sel   = req_a[k*WIDTH +: WIDTH];
                b_sel   = req_b[k*WIDTH +: WIDTH];
                cin_sel = req_cin[k];
            end
        end
    end

    csel_add32 u_add (
        .a    (a_sel),
        .b    (b_sel),
        .cin  (cin_sel),
        .s    (sum),
        .cout (cout)
    );

`ifdef ADDER_SHARE_OVF_EN
    logic ovf;
    assign ovf = (a_sel[WIDTH-1] == b_sel[WIDTH-1]) & (sum[WIDTH-1] != a_sel[WIDTH-1]);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_s     <= '0;
            rsp_cout  <= 1'b0;
`ifdef ADDER_SHARE_OVF_EN
            rsp_ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, HOLD: begin
                    if (accept) begin
                        state     <= HOLD;
                        rsp_valid <= 1'b1;
                        rsp_id    <= idx;
                        rsp_s     <= sum;
                        rsp_cout  <= cout;
`ifdef ADDER_SHARE_OVF_EN
                        rsp_ovf   <= ovf;
`endif
                        ptr       <= (idx == ID_W'(NUM_REQ - 1)) ? '0 : idx + ID_W'(1);
                    end else if (state == HOLD && rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_share_arbiter.sv
module tb_adder_share_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int IW = 2;

    logic             clk;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic [N-1:0]     req_cin;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [IW-1:0]    rsp_id;
    logic [W-1:0]     rsp_s;
    logic             rsp_cout;
`ifdef ADDER_SHARE_OVF_EN
    logic             rsp_ovf;
`endif

    adder_share_arbiter #(
        .NUM_REQ (N),
        .WIDTH   (W),
        .ID_W    (IW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_s     (rsp_s),
        .rsp_cout  (rsp_cout)
`ifdef ADDER_SHARE_OVF_EN
        ,
        .rsp_ovf   (rsp_ovf)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [IW-1:0] id;
        logic [W-1:0]  s;
        logic          cout;
        logic          ovf;
    } rsp_t;

    rsp_t sb[$];

    // Independent reference model, evaluated at each falling edge.
    int   m_ptr     = 0;
    bit   m_hold    = 0;
    bit   m_pend    = 0;
    bit   prev_rst  = 0;

    always @(negedge clk) begin
        int          win;
        bit          can;
        logic [N-1:0] exp_rdy;
        logic [W:0]  full;
        logic [W-1:0] oa, ob;
        rsp_t        e;
        rsp_t        got;
        if (rst) begin
            chk("ready_in_reset", 64'(req_ready), 64'(0));
            if (prev_rst) begin
                chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
                chk("rst_rsp_s", 64'(rsp_s), 64'(0));
                chk("rst_rsp_cout", 64'(rsp_cout), 64'(0));
                chk("rst_rsp_id", 64'(rsp_id), 64'(0));
`ifdef ADDER_SHARE_OVF_EN
                chk("rst_rsp_ovf", 64'(rsp_ovf), 64'(0));
`endif
            end
            m_ptr  = 0;
            m_hold = 0;
            m_pend = 0;
            sb.delete();
            prev_rst = 1;
        end else begin
            prev_rst = 0;
            if (m_pend) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 64'(1), 64'(0));
                end else begin
                    e   = sb.pop_front();
                    got.id = rsp_id; got.s = rsp_s; got.cout = rsp_cout;
                    chk("rsp_id", 64'(got.id), 64'(e.id));
                    chk("rsp_s", 64'(got.s), 64'(e.s));
                    chk("rsp_cout", 64'(got.cout), 64'(e.cout));
`ifdef ADDER_SHARE_OVF_EN
                    chk("rsp_ovf", 64'(rsp_ovf), 64'(e.ovf));
`endif
                end
                m_pend = 0;
            end
            chk("rsp_valid", 64'(rsp_valid), 64'(m_hold));
            win = -1;
            for (int k = 0; k < N; k++) begin
                if (win < 0 && req_valid[(m_ptr + k) % N]) win = (m_ptr + k) % N;
            end
            can = !m_hold || rsp_ready;
            exp_rdy = '0;
            if (win >= 0 && can) exp_rdy[win] = 1'b1;
            chk("req_ready", 64'(req_ready), 64'(exp_rdy));
            if (win >= 0 && can) begin
                oa   = req_a[win*W +: W];
                ob   = req_b[win*W +: W];
                full = {1'b0, oa} + {1'b0, ob} + (W+1)'(req_cin[win]);
                e.id   = IW'(win);
                e.s    = full[W-1:0];
                e.cout = full[W];
                e.ovf  = (oa[W-1] == ob[W-1]) && (full[W-1] != oa[W-1]);
                sb.push_back(e);
                m_pend = 1;
                m_hold = 1;
                m_ptr  = (win + 1) % N;
            end else if (m_hold && rsp_ready) begin
                m_hold = 0;
            end
        end
    end

    typedef struct {
        int          id;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic        cin;
        logic [W-1:0] s;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic load_all_slots();
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = 32'h1000_0000 * (i + 1) + 32'h11;
            req_b[i*W +: W] = 32'h0000_0100 * (i + 3);
            req_cin[i]      = i[0];
        end
    endtask

    task automatic do_reset(input int cycles);
        @(posedge clk); #1;
        rst = 1'b1;
        req_valid = '1;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
        req_valid = '0;
    endtask

    initial begin
        int           grant_seq[6];
        logic [W-1:0] cap_s;
        logic [IW-1:0] cap_id;
        logic         cap_cout;

        vecs[0] = '{2, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vecs[1] = '{0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        vecs[2] = '{1, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0, 1'b0};
        vecs[3] = '{3, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
        vecs[4] = '{1, 32'h1234_5678, 32'h1111_1111, 1'b1, 32'h2345_678A, 1'b0, 1'b0};
        vecs[5] = '{0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[6] = '{3, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b0};
        vecs[7] = '{2, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1};
        grant_seq = '{0, 1, 2, 3, 0, 1};

        rst       = 1'b1;
        req_valid = '1;
        rsp_ready = 1'b1;
        load_all_slots();
        repeat (3) @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = '0;
        repeat (2) @(posedge clk);

        // Table-driven single-requester vectors
        for (int v = 0; v < 8; v++) begin
            #1;
            req_valid = '0;
            req_valid[vecs[v].id] = 1'b1;
            req_a[vecs[v].id*W +: W] = vecs[v].a;
            req_b[vecs[v].id*W +: W] = vecs[v].b;
            req_cin[vecs[v].id]      = vecs[v].cin;
            @(posedge clk); #1;
            req_valid = '0;
            @(negedge clk);
            chk("vec_valid", 64'(rsp_valid), 64'(1));
            chk("vec_s", 64'(rsp_s), 64'(vecs[v].s));
            chk("vec_cout", 64'(rsp_cout), 64'(vecs[v].cout));
            chk("vec_id", 64'(rsp_id), 64'(vecs[v].id));
`ifdef ADDER_SHARE_OVF_EN
            chk("vec_ovf", 64'(rsp_ovf), 64'(vecs[v].ovf));
`endif
            @(posedge clk);
        end

        // Round-robin order with all requesters valid from a fresh reset
        load_all_slots();
        do_reset(2);
        req_valid = '1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rr_grant", 64'(req_ready), 64'(4'b0001 << grant_seq[i]));
            @(posedge clk); #1;
        end

        // Backpressure: response frozen, no grants
        rsp_ready = 1'b0;
        @(negedge clk);
        cap_s = rsp_s; cap_id = rsp_id; cap_cout = rsp_cout;
        for (int i = 0; i < 5; i++) begin
            chk("bp_ready", 64'(req_ready), 64'(0));
            chk("bp_valid", 64'(rsp_valid), 64'(1));
            chk("bp_s", 64'(rsp_s), 64'(cap_s));
            chk("bp_id", 64'(rsp_id), 64'(cap_id));
            chk("bp_cout", 64'(rsp_cout), 64'(cap_cout));
            @(negedge clk);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_release_valid", 64'(rsp_valid), 64'(1));
        chk("bp_release_new_id", 64'(rsp_id != cap_id), 64'(1));

        // Reset while holding a response
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("hold_before_rst", 64'(rsp_valid), 64'(1));
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_hold_rst_valid", 64'(rsp_valid), 64'(0));
        @(posedge clk); #1;
        rst       = 1'b0;
        rsp_ready = 1'b1;
        req_valid = '1;
        @(negedge clk);
        chk("post_rst_grant", 64'(req_ready), 64'(4'b0001));
        @(posedge clk); #1;
        req_valid = '0;
        repeat (4) @(posedge clk);
        #1;
        chk("sb_drained", 64'(sb.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, failures so far %0d", n_fail);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/adder_share_arbiter.md
# adder_share_arbiter

Round-robin arbiter and sequencer that shares a single 32-bit carry-select adder among `NUM_REQ` requesters. Each requester presents operands with a valid/ready handshake. The arbiter grants one requester per cycle, drives the shared adder combinationally, and captures sum and carry-out in a registered response stage tagged with the requester ID. The block sits between several arithmetic clients (address generators, accumulators) and the adder datapath, replacing per-client adders.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters. Legal range is 2..8.
- `WIDTH`, default 32: operand width. Must equal 32, the shared adder width; elaboration fails otherwise.
- `ID_W`, default `$clog2(NUM_REQ)`: width of the response ID.

Ports (one clock; reset is synchronous and active-high):
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req_valid` input `NUM_REQ`: per-requester request valid.
- `req_ready` output `NUM_REQ`: per-requester accept. One-hot or zero.
- `req_a` input `NUM_REQ*WIDTH`: packed operand A. Requester i occupies `[i*WIDTH +: WIDTH]`.
- `req_b` input `NUM_REQ*WIDTH`: packed operand B, same packing as `req_a`.
- `req_cin` input `NUM_REQ`: per-requester carry-in.
- `rsp_valid` output 1: response holds a valid result.
- `rsp_ready` input 1: consumer accepts the response.
- `rsp_id` output `ID_W`: index of the requester that produced the result.
- `rsp_s` output `WIDTH`: sum.
- `rsp_cout` output 1: carry-out.
- `rsp_ovf` output 1: signed overflow. Present only with `ADDER_SHARE_OVF_EN`.

## Operation
State machine:
- Two states: `IDLE` (response register empty) and `HOLD` (response valid, awaiting `rsp_ready`).
- `can_issue = (state==IDLE) | rsp_ready`.

Grant:
- Round-robin pointer `ptr`, reset value 0.
- The winner is the first i with `req_valid[i]`, scanning `ptr, ptr+1, …` modulo `NUM_REQ`.
- `req_ready[winner] = can_issue`. All other `req_ready` bits are 0.
- `req_ready` never depends on the winner's own `req_valid`, except through winner selection.

Accept:
- On an accept, the winner's `a`, `b` and `cin` drive the adder.
- `{rsp_s, rsp_cout, rsp_id}` are registered.
- `ptr` becomes `(winner+1) mod NUM_REQ`. Wrap from `NUM_REQ-1` goes to 0.

Transitions:
- `IDLE` → `HOLD` on accept.
- `HOLD` stays in `HOLD` when `rsp_ready` and a new accept occur in the same cycle. The new result replaces the old one with no bubble.
- `HOLD` → `IDLE` when `rsp_ready` is high and no request is valid.
- `HOLD` with `!rsp_ready`: all response outputs are stable, all `req_ready` are 0, and `ptr` is frozen.

Other rules:
- No request valid: `ptr` is unchanged.
- Arithmetic is modulo 2^32. `rsp_cout` is bit 32 of `a+b+cin`.

## Timing
- Latency: request accepted in cycle N → `rsp_valid` high in cycle N+1.
- Throughput: one result per cycle while `rsp_ready` is high.
- Reset values: `rsp_valid` 0, `rsp_s` 0, `rsp_cout` 0, `rsp_id` 0, `rsp_ovf` 0, `ptr` 0, state `IDLE`.
- `req_ready` is all-zero during any cycle in which `rst` is high.
- Reset mid-`HOLD` discards the pending response. No handshake completes in the reset cycle.
- The adder path is combinational from the operand mux to the response register. The mux-plus-adder path is the critical path.

## Configuration
- `ADDER_SHARE_OVF_EN` defined:
  - Adds the `rsp_ovf` port.
  - `rsp_ovf = (a[31]==b[31]) & (sum[31]!=a[31])`, registered with the sum.
- Macro undefined: the port is absent and no overflow logic is generated.

## Structure
- Shared package `adder_share_pkg` contains:
  - the state enum `adder_share_state_t`, with `IDLE` and `HOLD`;
  - constant `ADDER_SHARE_WIDTH = 32`.
- The one sub-module is `rr_pick`: combinational round-robin winner select. Inputs: valid vector and `ptr`. Outputs: one-hot grant and encoded index.
- Exactly one instance of the team's 32-bit carry-select adder.

## Test plan
- Reset: assert `rst` for 2 cycles with all `req_valid` high. Required: `req_ready==0`, `rsp_valid==0`, `ptr==0`.
- Single requester 2: `a=0xFFFFFFFF`, `b=1`, `cin=0`. Required next cycle: `rsp_valid=1`, `rsp_s=0`, `rsp_cout=1`, `rsp_id=2`.
- All four requesters valid continuously, `rsp_ready=1`. Required: grants 0,1,2,3,0,1 in consecutive cycles and `rsp_id` follows one cycle later.
- Backpressure: `rsp_ready=0` for 5 cycles while `rsp_valid=1`. Required: `rsp_s`, `rsp_id` and `rsp_cout` constant, `req_ready==0`. Releasing `rsp_ready` with a request pending gives a new result the next cycle with no bubble.
- Reset mid-`HOLD`: assert `rst` while `rsp_valid=1` and `rsp_ready=0`. Required: `rsp_valid=0` next cycle and the next grant goes to requester 0.
- With `ADDER_SHARE_OVF_EN`: `0x7FFFFFFF+1` gives `rsp_ovf=1` and `rsp_cout=0`. `0xFFFFFFFF+1` gives `rsp_ovf=0` and `rsp_cout=1`.
